// File: rtl/qdec_bin_arb.sv
// rtl/qdec_bin_arb.sv - round-robin arbiter/sequencer sharing one CABAC bin decode engine
module qdec_bin_arb #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 64,
  localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_run,
  input  logic [NREQ*ADDR_W-1:0] req_ctx_addr,
  input  logic [NREQ-1:0]        req_epmode,
  output logic [NREQ-1:0]        req_grant,
  output logic [NREQ-1:0]        bin_vld,
  output logic                   bin,
  output logic [ADDR_W-1:0]      ctx_addr,
  output logic                   ctx_addr_vld,
  output logic                   dec_run,
  output logic                   EPMode,
  input  logic                   dec_rdy,
  input  logic                   ruiBin,
  input  logic                   ruiBin_vld,
  output logic                   busy,
  output logic [OW-1:0]          owner,
  output logic                   err
);

  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CTX_LOAD = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_WAIT_BIN = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   win;
  logic            any_req;
  logic [WD_W-1:0] wdog;
  logic            wdog_expired;

  assign any_req      = |req_run;
  assign wdog_expired = (wdog == WD_W'(TIMEOUT - 1));

  // Scan downward so the set bit closest to the pointer (smallest offset) wins.
  always_comb begin
    int idx;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_run[idx]) win = OW'(idx);
    end
  end

  // The engine latches the address on the strobe, so dec_run may issue
  // straight out of CTX_LOAD when the engine is already ready.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (any_req) state_nxt = req_epmode[win] ? S_RUN : S_CTX_LOAD;
      S_CTX_LOAD: state_nxt = dec_rdy ? S_WAIT_BIN : S_RUN;
      S_RUN:      if (dec_rdy) state_nxt = S_WAIT_BIN;
      S_WAIT_BIN: if (ruiBin_vld || wdog_expired) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      wdog         <= '0;
      req_grant    <= '0;
      bin_vld      <= '0;
      bin          <= 1'b0;
      ctx_addr     <= '0;
      ctx_addr_vld <= 1'b0;
      dec_run      <= 1'b0;
      EPMode       <= 1'b0;
      busy         <= 1'b0;
      owner        <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != S_IDLE);
      req_grant    <= '0;
      bin_vld      <= '0;
      ctx_addr_vld <= 1'b0;
      dec_run      <= 1'b0;
      if (ruiBin_vld && state != S_WAIT_BIN) err <= 1'b1;
      case (state)
        S_IDLE: begin
          EPMode <= 1'b0;
          if (any_req) begin
            owner          <= win;
            ptr            <= (int'(win) == NREQ - 1) ? '0 : win + OW'(1);
            req_grant[win] <= 1'b1;
            ctx_addr       <= req_ctx_addr[win*ADDR_W +: ADDR_W];
            EPMode         <= req_epmode[win];
            ctx_addr_vld   <= ~req_epmode[win];
          end
        end
        S_CTX_LOAD, S_RUN: begin
          if (dec_rdy) begin
            dec_run <= 1'b1;
            wdog    <= '0;
          end
        end
        S_WAIT_BIN: begin
          // A bin arriving on the expiry cycle still wins over the timeout.
          if (ruiBin_vld) begin
            bin            <= ruiBin;
            bin_vld[owner] <= 1'b1;
          end else if (wdog_expired) begin
            err <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/qdec_bin_arb.md
Name: qdec_bin_arb

Overview:
Arbiter and sequencer sharing the single CABAC bin decoding engine between NREQ syntax-element sub-FSMs (dqp, cqp, residual and similar).
- Accepts one-bin decode requests and grants them round-robin.
- Drives the context-address load and the dec_run pulse to the engine, then routes the returned bin to the owning requester.
- Flags protocol errors: stray bins and engine timeouts.

Parameters:
NREQ, 3, number of requesters (2..8)
ADDR_W, 10, context address width
TIMEOUT, 64, max cycles in WAIT_BIN before abort (power of two, >=4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_run  in  NREQ  per-requester request for one bin; held until the matching req_grant
req_ctx_addr  in  NREQ*ADDR_W  per-requester context address, slice i at [i*ADDR_W +: ADDR_W]
req_epmode  in  NREQ  per-requester bypass (EP) bin flag
req_grant  out  NREQ  one-hot, one-cycle pulse: request accepted
bin_vld  out  NREQ  one-hot, one-cycle pulse: bin returned to that requester
bin  out  1  decoded bin value, valid when any bin_vld bit is 1
ctx_addr  out  ADDR_W  context address to engine
ctx_addr_vld  out  1  one-cycle context load strobe
dec_run  out  1  one-cycle decode start pulse
EPMode  out  1  bypass mode for the current bin; held from grant until bin return
dec_rdy  in  1  engine ready for dec_run
ruiBin  in  1  engine bin value
ruiBin_vld  in  1  engine bin valid
busy  out  1  high when state != IDLE
owner  out  $clog2(NREQ)  index of the current grantee
err  out  1  sticky error, cleared only by rst

Behaviour:
- All outputs are registered.
- Reset (async, any state): every output is 0, state = IDLE, round-robin pointer = 0, watchdog = 0.
- States: IDLE, CTX_LOAD, RUN, WAIT_BIN.
- IDLE:
  - If any req_run bit is 1, select the first set bit at or after the pointer, with wrap-around.
  - Latch owner, ctx_addr and EPMode from that requester.
  - Pointer becomes (winner+1) mod NREQ.
  - Next cycle: req_grant[winner] = 1; go to RUN if epmode = 1, else CTX_LOAD.
  - req_run, req_ctx_addr and req_epmode are sampled only in IDLE.
- CTX_LOAD: ctx_addr_vld = 1 for exactly this cycle, then RUN.
- RUN:
  - When dec_rdy = 1, issue dec_run = 1 for one cycle and go to WAIT_BIN; clear the watchdog.
  - While dec_rdy = 0, stay in RUN with dec_run = 0.
- WAIT_BIN:
  - Watchdog increments each cycle.
  - On ruiBin_vld = 1: next cycle bin = ruiBin and bin_vld[owner] = 1; go to IDLE.
  - If the watchdog reaches TIMEOUT-1 with no bin: set err, go to IDLE, no bin_vld pulse.
- Latency:
  - Context bin: req seen in IDLE at cycle t; grant and ctx_addr_vld at t+1; dec_run at t+2 (if dec_rdy).
  - EP bin: grant at t+1, dec_run at t+2.
  - bin_vld follows ruiBin_vld by one cycle.
  - Next arbitration happens in the IDLE cycle after bin_vld, so back-to-back bins have at least one IDLE cycle between them.
- Requester contract:
  - Drop req_run the cycle after req_grant.
  - A still-asserted req_run in the next IDLE is a new request.
- Errors:
  - ruiBin_vld while not in WAIT_BIN sets err and is otherwise ignored.
  - ruiBin_vld in the same cycle that the watchdog expires is treated as a valid bin; err is not set.
- Simultaneous requests: exactly one grant per arbitration; losing requesters wait and are served in pointer order.
- NREQ=1: the pointer is constant 0, and owner is 1 bit wide and always 0.

Test Plan:
- Single context bin: req_run=3'b001, addr=0x05A, ep=0, dec_rdy=1, engine returns ruiBin=1 three cycles after dec_run. Expect:
  - req_grant=001 and ctx_addr_vld=1 with ctx_addr=0x05A at t+1;
  - dec_run at t+2;
  - bin_vld=001 with bin=1 one cycle after ruiBin_vld;
  - err=0.
- EP bin: req_run=3'b100, ep=1. Expect no ctx_addr_vld, grant at t+1, dec_run at t+2, EPMode=1 until bin_vld=100.
- Fairness: req_run=3'b111 held continuously (re-asserted after each grant). Expect grant order 001, 010, 100, 001; owner sequence 0, 1, 2, 0.
- dec_rdy stall: dec_rdy=0 for 5 cycles in RUN. Expect dec_run=0 throughout, then exactly one dec_run pulse when dec_rdy rises.
- Timeout: with TIMEOUT=64 and no ruiBin_vld after dec_run, expect err=1 64 cycles after dec_run, no bin_vld, busy=0, and err held until rst.
- Reset mid-operation: assert rst in WAIT_BIN. Expect all outputs 0 immediately and pointer=0; after release, req_run=3'b011 is granted to requester 0 first.
